// File: rtl/wb_instr_loader.sv
// Wishbone responder for loading/reading the jacaranda-8 instruction memory and holding the core in reset.
// Optional checksum register is enabled by defining LOADER_CHECKSUM_EN.
module wb_instr_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        cpu_reset_o,
    output logic [7:0]  mem_addr_o,
    output logic [7:0]  mem_wdata_o,
    output logic        mem_we_o,
    input  logic [7:0]  mem_rdata_i
);

    localparam logic [7:0] OFF_CTRL   = 8'h00;
    localparam logic [7:0] OFF_STATUS = 8'h04;
    localparam logic [7:0] OFF_ADDR   = 8'h08;
    localparam logic [7:0] OFF_LOAD   = 8'h0C;
    localparam logic [7:0] OFF_CKSUM  = 8'h10;

    typedef enum logic [1:0] {S_IDLE, S_RD_WAIT, S_ACK} state_t;
    // Side effect deferred to the ACK cycle, so register changes land at the end of the ack.
    typedef enum logic [2:0] {OP_NONE, OP_CTRL, OP_ADDR, OP_LOAD_WR, OP_INC, OP_ERR} op_t;

    state_t      state_q;
    op_t         op_q;
    logic [7:0]  op_data_q;
    logic        hold_q;
    logic        err_q;
    logic        wrap_q;
    logic [7:0]  load_addr_q;
    logic        ack_q;
    logic [7:0]  dat_q;
    logic        we_q;
    logic [7:0]  wdata_q;
    logic [7:0]  cksum_val;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  cksum_q;
    assign cksum_val = cksum_q;
`else
    assign cksum_val = 8'h00;
`endif

    logic       req_valid;
    logic [7:0] off;
    logic       is_load;
    logic [7:0] rd_val;
    logic       unused_ok;

    assign req_valid = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign off       = wbs_adr_i[7:0];
    assign is_load   = (off == OFF_LOAD);
    assign unused_ok = ^{wbs_dat_i[31:8], wbs_sel_i[3:1]};

    always_comb begin
        rd_val = 8'h00;
        case (off)
            OFF_CTRL:   rd_val = {7'b0, hold_q};
            OFF_STATUS: rd_val = {6'b0, wrap_q, err_q};
            OFF_ADDR:   rd_val = load_addr_q;
            OFF_CKSUM:  rd_val = cksum_val;
            default:    rd_val = 8'h00;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q     <= S_IDLE;
            op_q        <= OP_NONE;
            op_data_q   <= 8'h00;
            hold_q      <= 1'b1;
            err_q       <= 1'b0;
            wrap_q      <= 1'b0;
            load_addr_q <= 8'h00;
            ack_q       <= 1'b0;
            dat_q       <= 8'h00;
            we_q        <= 1'b0;
            wdata_q     <= 8'h00;
`ifdef LOADER_CHECKSUM_EN
            cksum_q     <= 8'h00;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    ack_q <= 1'b0;
                    we_q  <= 1'b0;
                    dat_q <= 8'h00;
                    op_q  <= OP_NONE;
                    if (req_valid) begin
                        if (is_load && hold_q && !wbs_we_i) begin
                            state_q <= S_RD_WAIT;
                        end else begin
                            state_q <= S_ACK;
                            ack_q   <= 1'b1;
                            if (!wbs_we_i) begin
                                dat_q <= rd_val;
                                if (is_load) op_q <= OP_ERR;
                            end else if (wbs_sel_i[0]) begin
                                op_data_q <= wbs_dat_i[7:0];
                                case (off)
                                    OFF_CTRL: op_q <= OP_CTRL;
                                    OFF_ADDR: op_q <= OP_ADDR;
                                    OFF_LOAD: begin
                                        if (hold_q) begin
                                            op_q    <= OP_LOAD_WR;
                                            we_q    <= 1'b1;
                                            wdata_q <= wbs_dat_i[7:0];
                                        end else begin
                                            op_q <= OP_ERR;
                                        end
                                    end
                                    default: op_q <= OP_NONE;
                                endcase
                            end
                        end
                    end
                end
                S_RD_WAIT: begin
                    state_q <= S_ACK;
                    ack_q   <= 1'b1;
                    dat_q   <= mem_rdata_i;
                    op_q    <= OP_INC;
                end
                S_ACK: begin
                    state_q <= S_IDLE;
                    ack_q   <= 1'b0;
                    we_q    <= 1'b0;
                    dat_q   <= 8'h00;
                    op_q    <= OP_NONE;
                    case (op_q)
                        OP_CTRL: begin
                            hold_q <= op_data_q[0];
                            if (op_data_q[1]) begin
                                wrap_q <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                                cksum_q <= 8'h00;
`endif
                            end
                        end
                        OP_ADDR: begin
                            load_addr_q <= op_data_q;
`ifdef LOADER_CHECKSUM_EN
                            cksum_q <= 8'h00;
`endif
                        end
                        OP_LOAD_WR: begin
                            load_addr_q <= load_addr_q + 8'd1;
                            if (load_addr_q == 8'hFF) wrap_q <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
                            cksum_q <= cksum_q + wdata_q;
`endif
                        end
                        OP_INC: begin
                            load_addr_q <= load_addr_q + 8'd1;
                            if (load_addr_q == 8'hFF) wrap_q <= 1'b1;
                        end
                        OP_ERR:  err_q <= 1'b1;
                        default: op_q  <= OP_NONE;
                    endcase
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign wbs_ack_o   = ack_q;
    assign wbs_dat_o   = {24'h0, dat_q};
    assign cpu_reset_o = hold_q;
    assign mem_addr_o  = load_addr_q;
    assign mem_wdata_o = wdata_q;
    assign mem_we_o    = we_q;

endmodule

// File: doc/wb_instr_loader.md
# wb_instr_loader

Wishbone responder that lets the management SoC load and read back the 256-byte instruction memory of the jacaranda-8 core, and hold or release the core's reset. It sits between the user-project Wishbone port and the instruction memory write/read port. It replaces logic-analyzer based program loading with memory-mapped register access.

## Interface
Parameters:
- BASE_ADDR, 32'h3000_0000: window base; only bits [31:8] are compared.

Ports:
- wb_clk_i  input  1  system clock; all logic on rising edge.
- wb_rst_n  input  1  asynchronous, active-low reset.
- wbs_stb_i  input  1  Wishbone strobe.
- wbs_cyc_i  input  1  Wishbone cycle.
- wbs_we_i  input  1  1 = write, 0 = read.
- wbs_sel_i  input  4  byte lanes; only sel[0] is used.
- wbs_adr_i  input  32  byte address.
- wbs_dat_i  input  32  write data; only [7:0] is used.
- wbs_ack_o  output  1  single-cycle acknowledge.
- wbs_dat_o  output  32  read data, zero-extended from 8 bits.
- cpu_reset_o  output  1  core reset; 1 = core held.
- mem_addr_o  output  8  instruction memory address.
- mem_wdata_o  output  8  instruction memory write data.
- mem_we_o  output  1  instruction memory write strobe, one cycle.
- mem_rdata_i  input  8  instruction memory read data, valid 1 cycle after mem_addr_o.

## Operation
- A request is valid when stb & cyc & (adr[31:8] == BASE_ADDR[31:8]).
- Requests outside the window are ignored, with no ack.
- Register map, by adr[7:0]:
  - 0x00 CTRL (rw): bit0 = hold; drives cpu_reset_o; reset value 1. Writing 1 to bit1 clears STATUS.wrap and the checksum; bit1 is self-clearing and reads 0.
  - 0x04 STATUS (ro): bit0 = err, a sticky flag set when LOAD_DATA is accessed while hold = 0. bit1 = wrap, set when load_addr wraps 0xFF->0x00.
  - 0x08 LOAD_ADDR (rw): 8-bit pointer. Writing it also clears the checksum.
  - 0x0C LOAD_DATA:
    - Write, with hold = 1: writes dat_i[7:0] to memory at load_addr, then load_addr increments.
    - Read, with hold = 1: returns memory at load_addr, then load_addr increments.
  - 0x10 CHECKSUM (ro): see Configuration.
  - Any other offset: reads 0; writes are ignored; both are acked.
- Writes with sel[0] = 0 are acked without side effects.
- LOAD_DATA accesses while hold = 0 are acked without a memory write or increment. Reads return 0. err is set.
- mem_addr_o is driven from load_addr at all times.
- load_addr arithmetic is 8-bit and wraps modulo 256.
- FSM:
  - IDLE -> ACK on a valid register access or LOAD_DATA write.
  - IDLE -> RD_WAIT on a permitted LOAD_DATA read.
  - RD_WAIT -> ACK, capturing mem_rdata_i.
  - ACK -> IDLE unconditionally.

## Timing
- Reset values: wbs_ack_o 0, wbs_dat_o 0, cpu_reset_o 1, mem_we_o 0, mem_addr_o 0, mem_wdata_o 0. All registers 0 except hold = 1.
- Reset asserted mid-transaction aborts it: no ack, no memory write.
- Register read/write: request sampled in IDLE at cycle N; ack high for exactly cycle N+1; read data valid with ack.
- LOAD_DATA write: mem_we_o and mem_wdata_o asserted in cycle N+1, coincident with ack; load_addr increments at the end of N+1.
- LOAD_DATA read: RD_WAIT in N+1; ack and data in N+2; increment at the end of N+2.
- The cycle after ack is always IDLE, so stb held high cannot produce a second ack without one idle cycle. Minimum transaction spacing is 2 cycles (3 for LOAD_DATA reads).
- cpu_reset_o changes at the end of the CTRL write ack cycle.
- Simultaneous clear (CTRL bit1) and wrap cannot occur, since the accesses are serialized.

## Configuration
- LOADER_CHECKSUM_EN defined:
  - CHECKSUM holds the 8-bit modulo-256 sum of all bytes successfully written via LOAD_DATA.
  - It is cleared by reset, by a LOAD_ADDR write, and by CTRL bit1.
- Not defined: no checksum register is synthesized; offset 0x10 reads 0.

## Test plan
- Reset: wb_rst_n = 0 -> cpu_reset_o = 1, ack = 0, mem_we_o = 0. Read CTRL -> 0x01, acked at N+1.
- Burst load: write LOAD_ADDR = 0xFE, then LOAD_DATA 0x11, 0x22, 0x33:
  - mem_we_o pulses at addresses 0xFE, 0xFF, 0x00.
  - STATUS reads 0x02.
  - CHECKSUM = 0x66 with the macro, 0x00 without.
- Readback: LOAD_ADDR = 0xFE, read LOAD_DATA twice -> 0x11, 0x22, each acked exactly 2 cycles after the request.
- Run protection: write CTRL = 0x00, then write LOAD_DATA 0x55 -> acked, no mem_we_o, STATUS.err = 1, load_addr unchanged.
- Held strobe / foreign address: stb held 4 cycles on CTRL -> acks only at cycles 1 and 3. Access to BASE_ADDR + 0x100 -> no ack.
- Mid-transaction reset: assert wb_rst_n = 0 during RD_WAIT -> no ack; cpu_reset_o = 1; load_addr = 0.
